// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared defaults and types for the register-pending scoreboard.
//   AW       : register-number width
//   NREG     : number of architectural registers (2**AW)
//   CW       : pending-counter width per register
//   regnum_t : a register number
//   pcnt_t   : a pending count
//   PCNT_MAX : the largest pending count a counter can hold
package reg_scoreboard_pkg;

    localparam int AW   = 5;
    localparam int NREG = 2 ** AW;
    localparam int CW   = 2;

    typedef logic [AW-1:0] regnum_t;
    typedef logic [CW-1:0] pcnt_t;

    localparam pcnt_t PCNT_MAX = pcnt_t'((1 << CW) - 1);

endpackage

// File: rtl/sb_pend_counter.sv
// sb_pend_counter
// One saturating up/down pending-write counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : one write issued to this register this cycle
//   dec[1:0]   : writes retired this cycle (write-back plus cancel, 0..2)
//   count      : current (registered) pending count
//   ovf        : this cycle's increment is lost because the count is at maximum
//   unf        : this cycle's retirements exceed the pending writes
module sb_pend_counter #(
    parameter int CW = reg_scoreboard_pkg::CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic [1:0]    dec,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    // Two's-complement CW+2-bit sum: bit CW+1 is the sign, bit CW flags a
    // result above the counter range (range is -2 .. 2**CW).
    logic [CW+1:0] sum;

    always_comb begin
        // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
        sum     = {2'b00, count_q} + (CW+2)'(inc) - (CW+2)'(dec);
        count_d = sum[CW-1:0];
        if (sum[CW+1]) begin
            count_d = '0;
        end else if (sum[CW]) begin
            count_d = CNT_MAX;
        end
    end

    assign ovf   = inc && (dec == 2'd0) && (count_q == CNT_MAX);
    assign unf   = sum[CW+1];
    assign count = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Register-pending scoreboard beside the ID stage. Counts in-flight writes
// per destination register, answers same-cycle busy queries for rs/rt and
// raises the decode stall request. Register 0 is never tracked.
// Optional feature macro: REG_SCOREBOARD_WB_BYPASS_EN -- a register with
// exactly one pending write reports not busy in the cycle its write-back
// arrives (register file writes first half, reads second half).
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   issue_valid, issue_dst   : a register-writing instruction leaves decode
//   wb_valid, wb_dst         : write-back of a register
//   cancel_valid, cancel_dst : an issued instruction is squashed
//   rs, rt                   : source registers of the instruction in decode
//   rs_busy, rt_busy         : source has pending writes
//   stall                    : rs_busy | rt_busy
//   any_busy                 : some register has a nonzero count (registered only)
//   err_ovf, err_unf         : sticky overflow / underflow flags, cleared by reset
module reg_scoreboard #(
    parameter int AW   = reg_scoreboard_pkg::AW,
    parameter int NREG = reg_scoreboard_pkg::NREG,
    parameter int CW   = reg_scoreboard_pkg::CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_dst,
    input  logic          wb_valid,
    input  logic [AW-1:0] wb_dst,
    input  logic          cancel_valid,
    input  logic [AW-1:0] cancel_dst,
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] rt,
    output logic          rs_busy,
    output logic          rt_busy,
    output logic          stall,
    output logic          any_busy,
    output logic          err_ovf,
    output logic          err_unf
);

    logic [CW-1:0]   count [NREG];
    logic [NREG-1:0] nz;
    logic [NREG-1:0] ovf;
    logic [NREG-1:0] unf;
    logic            err_ovf_q;
    logic            err_unf_q;

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (r == 0) begin : g_r0
            // r0 is hardwired zero: no counter, never busy, never errors.
            assign count[r] = '0;
            assign ovf[r]   = 1'b0;
            assign unf[r]   = 1'b0;
        end else begin : g_rn
            logic       inc;
            logic [1:0] dec;

            assign inc = issue_valid && (issue_dst == AW'(r));
            assign dec = {1'b0, wb_valid && (wb_dst == AW'(r))}
                       + {1'b0, cancel_valid && (cancel_dst == AW'(r))};

            sb_pend_counter #(.CW(CW)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .inc   (inc),
                .dec   (dec),
                .count (count[r]),
                .ovf   (ovf[r]),
                .unf   (unf[r])
            );
        end
        assign nz[r] = |count[r];
    end

    always_comb begin
        rs_busy = nz[rs];
        rt_busy = nz[rt];
`ifdef REG_SCOREBOARD_WB_BYPASS_EN
        // Only the last outstanding write can be bypassed; cancels never bypass.
        if (wb_valid && (wb_dst == rs) && (count[rs] == CW'(1))) begin
            rs_busy = 1'b0;
        end
        if (wb_valid && (wb_dst == rt) && (count[rt] == CW'(1))) begin
            rt_busy = 1'b0;
        end
`endif
    end

    assign stall    = rs_busy | rt_busy;
    assign any_busy = |nz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_q | (|ovf);
            err_unf_q <= err_unf_q | (|unf);
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_unf = err_unf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
// Directed-vector bench for reg_scoreboard. Each stimulus cycle pushes its
// hand-computed expected outputs into a queue; a monitor on the falling
// edge pops one entry per cycle and compares. Expectations inside a
// write-back cycle depend on REG_SCOREBOARD_WB_BYPASS_EN.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

`ifdef REG_SCOREBOARD_WB_BYPASS_EN
    localparam bit WB1_BUSY = 1'b0;  // count 1 + matching wb reads not busy
`else
    localparam bit WB1_BUSY = 1'b1;
`endif

    typedef struct {
        string name;
        logic  rsb;
        logic  rtb;
        logic  stl;
        logic  anyb;
        logic  ovf;
        logic  unf;
    } exp_t;

    logic    clk;
    logic    rst_n;
    logic    issue_valid;
    regnum_t issue_dst;
    logic    wb_valid;
    regnum_t wb_dst;
    logic    cancel_valid;
    regnum_t cancel_dst;
    regnum_t rs;
    regnum_t rt;
    logic    rs_busy;
    logic    rt_busy;
    logic    stall;
    logic    any_busy;
    logic    err_ovf;
    logic    err_unf;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic e_ovf  = 1'b0;
    logic e_unf  = 1'b0;

    reg_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_dst    (issue_dst),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .cancel_valid (cancel_valid),
        .cancel_dst   (cancel_dst),
        .rs           (rs),
        .rt           (rt),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .stall        (stall),
        .any_busy     (any_busy),
        .err_ovf      (err_ovf),
        .err_unf      (err_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per stimulus cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        logic [5:0] act;
        logic [5:0] req;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {rs_busy, rt_busy, stall, any_busy, err_ovf, err_unf};
                req = {e.rsb, e.rtb, e.stl, e.anyb, e.ovf, e.unf};
                n_vec++;
                if (act !== req) begin
                    n_miss++;
                    $display("FAIL %s: got {rs,rt,stall,any,ovf,unf}=%b expected %b",
                             e.name, act, req);
                end
            end
        end
    end

    // Drive one cycle of inputs (starting just after a rising edge), push
    // the expected outputs for this cycle, then advance past the next edge.
    task automatic cyc(input string name,
                       input logic iv, input regnum_t id,
                       input logic wv, input regnum_t wd,
                       input logic cv, input regnum_t cd,
                       input regnum_t s, input regnum_t t,
                       input logic rsb, input logic rtb, input logic anyb);
        exp_t e;
        issue_valid  = iv;
        issue_dst    = id;
        wb_valid     = wv;
        wb_dst       = wd;
        cancel_valid = cv;
        cancel_dst   = cd;
        rs           = s;
        rt           = t;
        e.name = name;
        e.rsb  = rsb;
        e.rtb  = rtb;
        e.stl  = rsb | rtb;
        e.anyb = anyb;
        e.ovf  = e_ovf;
        e.unf  = e_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        issue_valid = 1'b0; issue_dst = '0;
        wb_valid = 1'b0;    wb_dst = '0;
        cancel_valid = 1'b0; cancel_dst = '0;
        rs = '0; rt = '0;
        @(posedge clk);
        #1;

        //   name           iv id  wv wd  cv cd  rs  rt   rsb rtb any
        cyc("reset_hold",   0, 0,  0, 0,  0, 0,  5,  9,   0,  0,  0);
        rst_n = 1'b1;
        cyc("idle",         0, 0,  0, 0,  0, 0,  5,  9,   0,  0,  0);

        // Basic hazard on r8.
        cyc("iss_r8",       1, 8,  0, 0,  0, 0,  5,  8,   0,  0,  0);
        cyc("r8_c1",        0, 0,  0, 0,  0, 0,  5,  8,   0,  1,  1);
        cyc("r8_c2",        0, 0,  0, 0,  0, 0,  8,  9,   1,  0,  1);
        cyc("r8_wb_c3",     0, 0,  1, 8,  0, 0,  5,  8,   0,  WB1_BUSY, 1);
        cyc("r8_c4",        0, 0,  0, 0,  0, 0,  8,  8,   0,  0,  0);

        // r0 is never tracked.
        cyc("iss_r0",       1, 0,  0, 0,  0, 0,  0,  0,   0,  0,  0);
        cyc("r0_after",     0, 0,  0, 0,  0, 0,  0,  0,   0,  0,  0);

        // Issue and wb to r4 in the same cycle with count 1.
        cyc("iss_r4",       1, 4,  0, 0,  0, 0,  4,  0,   0,  0,  0);
        cyc("r4_iss_wb",    1, 4,  1, 4,  0, 0,  4,  0,   WB1_BUSY, 0, 1);
        cyc("r4_still_1",   0, 0,  0, 0,  0, 0,  4,  0,   1,  0,  1);
        cyc("r4_wb",        0, 0,  1, 4,  0, 0,  4,  4,   WB1_BUSY, WB1_BUSY, 1);
        cyc("r4_clear",     0, 0,  0, 0,  0, 0,  4,  4,   0,  0,  0);

        // Saturation on r3.
        cyc("r3_iss1",      1, 3,  0, 0,  0, 0,  3,  0,   0,  0,  0);
        cyc("r3_iss2",      1, 3,  0, 0,  0, 0,  3,  0,   1,  0,  1);
        cyc("r3_iss3",      1, 3,  0, 0,  0, 0,  3,  0,   1,  0,  1);
        cyc("r3_iss4",      1, 3,  0, 0,  0, 0,  3,  0,   1,  0,  1);
        e_ovf = 1'b1;
        cyc("r3_held",      0, 0,  0, 0,  0, 0,  3,  0,   1,  0,  1);
        cyc("r3_wb1",       0, 0,  1, 3,  0, 0,  3,  0,   1,  0,  1);
        cyc("r3_wb2",       0, 0,  1, 3,  0, 0,  0,  3,   0,  1,  1);
        cyc("r3_wb3",       0, 0,  1, 3,  0, 0,  3,  0,   WB1_BUSY, 0, 1);
        cyc("r3_clear",     0, 0,  0, 0,  0, 0,  3,  3,   0,  0,  0);

        // Cancel and underflow on r10.
        cyc("r10_iss",      1, 10, 0, 0,  0, 0,  10, 0,   0,  0,  0);
        cyc("r10_cancel",   0, 0,  0, 0,  1, 10, 10, 0,   1,  0,  1);
        cyc("r10_clear",    0, 0,  0, 0,  0, 0,  10, 0,   0,  0,  0);
        cyc("r10_wb_unf",   0, 0,  1, 10, 0, 0,  10, 0,   0,  0,  0);
        e_unf = 1'b1;
        cyc("r10_unf",      0, 0,  0, 0,  0, 0,  10, 0,   0,  0,  0);
        cyc("r10_iss_a",    1, 10, 0, 0,  0, 0,  10, 0,   0,  0,  0);
        cyc("r10_iss_b",    1, 10, 0, 0,  0, 0,  10, 0,   1,  0,  1);
        cyc("r10_wb_cncl",  0, 0,  1, 10, 1, 10, 10, 0,   1,  0,  1);
        cyc("r10_zero",     0, 0,  0, 0,  0, 0,  10, 10,  0,  0,  0);

        // Reset mid-operation.
        cyc("iss_r2",       1, 2,  0, 0,  0, 0,  2,  0,   0,  0,  0);
        cyc("iss_r7",       1, 7,  0, 0,  0, 0,  2,  0,   1,  0,  1);
        cyc("iss_r31",      1, 31, 0, 0,  0, 0,  7,  2,   1,  1,  1);
        cyc("pend_check",   0, 0,  0, 0,  0, 0,  31, 7,   1,  1,  1);
        #2;
        rst_n = 1'b0;
        e_ovf = 1'b0;
        e_unf = 1'b0;
        cyc("rst_mid",      0, 0,  0, 0,  0, 0,  31, 2,   0,  0,  0);
        rst_n = 1'b1;
        cyc("post_rst_a",   0, 0,  0, 0,  0, 0,  7,  31,  0,  0,  0);
        cyc("post_rst_b",   0, 0,  0, 0,  0, 0,  2,  8,   0,  0,  0);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-pending scoreboard for the pipelined MIPS core. It records the destination register selected at decode for every in-flight writing instruction, and clears it when that instruction writes back or is squashed. It answers same-cycle busy queries for the two source registers of the instruction in decode, and produces the decode stall request. It sits beside the ID stage, fed by the destination-register select path and by the WB stage.

## Interface
Parameters:
- `AW`, 5: register-number width.
- `NREG`, 32: number of architectural registers, equal to 2**AW.
- `CW`, 2: pending-counter width per register; maximum `2**CW-1` outstanding writes.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `issue_valid` input 1: an instruction that writes a register leaves decode this cycle.
- `issue_dst` input AW: destination register of the issuing instruction.
- `wb_valid` input 1: write-back of a register this cycle.
- `wb_dst` input AW: register written back.
- `cancel_valid` input 1: an issued instruction is squashed and will never write back.
- `cancel_dst` input AW: destination of the squashed instruction.
- `rs`, `rt` input AW each: source registers of the instruction in decode.
- `rs_busy`, `rt_busy` output 1 each: the source has pending writes.
- `stall` output 1: `rs_busy | rt_busy`.
- `any_busy` output 1: some register has a nonzero count.
- `err_ovf` output 1: sticky; an issue arrived when the counter was already at maximum.
- `err_unf` output 1: sticky; a wb or cancel arrived when the counter was zero.

## Operation
- One unsigned `CW`-bit pending counter per register, r1..r(NREG-1). Register 0 is never tracked: events targeting r0 are ignored, and queries on r0 always return 0.
- Per cycle, per register r: `inc = issue_valid & issue_dst==r`, `dec = (wb_valid & wb_dst==r) + (cancel_valid & cancel_dst==r)`. The dec term can be 0, 1 or 2.
- Next count = count + inc − dec, evaluated in `CW+2`-bit signed arithmetic, then clamped to [0, 2**CW−1].
- `err_ovf` sets when count == max, inc = 1 and dec = 0; the counter holds at max.
- `err_unf` sets when the post-inc value is less than dec; the counter goes to 0.
- Issue and wb to the same register in the same cycle leave the count unchanged, with no error.
- `rs_busy` = (count[rs] != 0) before this cycle's update, subject to the bypass rule in Configuration. `rt_busy` follows the same rule.
- `stall` is purely combinational. The block does not gate `issue_valid`; upstream must not assert issue while `stall` is high.
- Error flags clear only on reset.

## Timing
- Reset, asynchronous: all counters are 0 and `err_ovf`/`err_unf` are 0. As a result `rs_busy`, `rt_busy`, `stall` and `any_busy` are 0 immediately.
- Reset asserted mid-operation discards all pending state; no events are replayed.
- Query latency is 0 cycles, combinational from the current counters and the same-cycle wb inputs.
- Update latency is 1 cycle: an issue in cycle N makes the register busy from cycle N+1.
- `any_busy` is derived from registered counters only, with no same-cycle terms.

## Configuration
- `REG_SCOREBOARD_WB_BYPASS_EN` defined:
  - A register whose count is exactly 1, with `wb_valid` and `wb_dst` matching in the current cycle, reports not busy in that cycle. This matches the register file's first-half write / second-half read.
  - A cancel does not bypass.
- Not defined: busy clears only from the cycle after the write-back edge.

## Structure
- Shared package `reg_scoreboard_pkg`:
  - `AW`, `NREG` and `CW` defaults.
  - `regnum_t` (AW bits) and `pcnt_t` (CW bits).
  - Constant `PCNT_MAX`.
- Sub-module `sb_pend_counter`: one saturating up/down counter with inputs inc and dec[1:0], outputs count, ovf and unf, and asynchronous active-low reset.
- The top instantiates NREG−1 copies via generate, and ORs the ovf/unf pulses into the sticky flags.

## Test plan
- Reset and idle: `rst_n` low, then high, then query rs=5, rt=9 → both busy 0, `stall` 0, `any_busy` 0, error flags 0.
- Basic hazard: issue r8 in cycle 0 → `rt_busy`=1 for rt=8 from cycle 1; wb r8 in cycle 3 → busy 0 in cycle 3 with bypass, cycle 4 without.
- r0 and same-cycle events:
  - Issue r0 → no busy, no error.
  - Issue r4 and wb r4 in the same cycle while the count is 1 → count stays 1, busy stays 1.
- Multiple outstanding: issue r3 three times, then a fourth issue → count 3, then `err_ovf`=1 with the count held at 3. Three wbs to r3 → busy 0.
- Cancel and underflow:
  - Issue r10, then cancel r10 → busy 0.
  - A further wb r10 → `err_unf`=1, count 0.
  - Simultaneous wb and cancel on r10 with count 2 → 0.
- Reset mid-operation: r2, r7 and r31 pending, then `rst_n` pulsed low asynchronously mid-cycle → `any_busy` drops at once, and all queries return 0 after release.
